// File: rtl/kf_regbank.sv
// Kalman-filter data bank: DEPTH x W register bank with one write port and NRD read ports,
// NSC scalar registers, a sequential bank-clear engine and sticky out-of-range detection.
module kf_regbank #(
    parameter int W      = 24,
    parameter int DEPTH  = 40,
    parameter int ADDRW  = 6,
    parameter int NRD    = 2,
    parameter int NSC    = 2,
    parameter int RD_LAT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [ADDRW-1:0]     wr_addr,
    input  logic [W-1:0]         wr_data,
    output logic                 wr_ready,
    input  logic [NRD*ADDRW-1:0] rd_addr,
    output logic [NRD*W-1:0]     rd_data,
    input  logic                 clr_req,
    output logic                 busy,
    output logic                 clr_done,
    output logic                 addr_err,
    input  logic [NSC-1:0]       sc_we,
    input  logic [NSC*W-1:0]     sc_d,
    output logic [NSC*W-1:0]     sc_q
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ADDRW-1:0] LAST = ADDRW'(DEPTH - 1);

    state_t           state_reg;
    logic [ADDRW-1:0] ptr_reg;
    logic             busy_reg;
    logic             clr_done_reg;
    logic             addr_err_reg;
    logic [W-1:0]     bank [DEPTH];
    logic [NRD-1:0]   rd_oor;
    logic             wr_ok;
    logic             wr_accept;
    logic             clr_accept;

    function automatic logic in_range(input logic [ADDRW-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    assign wr_ok      = in_range(wr_addr);
    assign wr_accept  = wr_en & ~busy_reg & wr_ok & ~rst;
    assign clr_accept = clr_req & ~busy_reg & ~rst;

    assign busy     = busy_reg;
    assign wr_ready = ~busy_reg;
    assign clr_done = clr_done_reg;
    assign addr_err = addr_err_reg;

    // Reset lands in CLEAR so the bank is zeroed by the walk rather than flash-cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= CLEAR;
            ptr_reg      <= '0;
            busy_reg     <= 1'b1;
            clr_done_reg <= (DEPTH == 1);
        end else begin
            case (state_reg)
                IDLE: begin
                    clr_done_reg <= 1'b0;
                    if (clr_req) begin
                        state_reg    <= CLEAR;
                        ptr_reg      <= '0;
                        busy_reg     <= 1'b1;
                        clr_done_reg <= (DEPTH == 1);
                    end
                end
                CLEAR: begin
                    if (ptr_reg == LAST) begin
                        state_reg    <= IDLE;
                        busy_reg     <= 1'b0;
                        clr_done_reg <= 1'b0;
                    end else begin
                        ptr_reg      <= ptr_reg + ADDRW'(1);
                        clr_done_reg <= ((ptr_reg + ADDRW'(1)) == LAST);
                    end
                end
                default: begin
                    state_reg    <= CLEAR;
                    ptr_reg      <= '0;
                    busy_reg     <= 1'b1;
                    clr_done_reg <= 1'b0;
                end
            endcase
        end
    end

    // The clear walk owns the write port while busy; external writes are dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (busy_reg)
                bank[ptr_reg] <= '0;
            else if (wr_accept)
                bank[wr_addr] <= wr_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [ADDRW-1:0] ra;
            logic             ra_ok;
            logic [W-1:0]     rd_comb;

            assign ra         = rd_addr[gi*ADDRW +: ADDRW];
            assign ra_ok      = in_range(ra);
            assign rd_oor[gi] = ~ra_ok;

            // Forwarding makes a same-cycle write visible, both combinationally and at the register.
            always_comb begin
                rd_comb = '0;
                if (!busy_reg && ra_ok)
                    rd_comb = (wr_accept && wr_addr == ra) ? wr_data : bank[ra];
            end

            if (RD_LAT == 1) begin : g_reg
                logic [W-1:0] rd_reg;
                always_ff @(posedge clk) begin
                    if (rst)
                        rd_reg <= '0;
                    else
                        rd_reg <= rd_comb;
                end
                assign rd_data[gi*W +: W] = rd_reg;
            end else begin : g_comb
                assign rd_data[gi*W +: W] = rd_comb;
            end
        end
    endgenerate

    // An accepted clear wins over any error raised in the same cycle.
    always_ff @(posedge clk) begin
        if (rst)
            addr_err_reg <= 1'b0;
        else if (clr_accept)
            addr_err_reg <= 1'b0;
        else if ((wr_en & ~busy_reg & ~wr_ok) | (|rd_oor))
            addr_err_reg <= 1'b1;
    end

    generate
        for (gi = 0; gi < NSC; gi++) begin : g_sc
            logic [W-1:0] sc_reg;
            always_ff @(posedge clk) begin
                if (rst)
                    sc_reg <= '0;
                else if (sc_we[gi])
                    sc_reg <= sc_d[gi*W +: W];
            end
            assign sc_q[gi*W +: W] = sc_reg;
        end
    endgenerate

endmodule

// File: tb/tb_kf_regbank.sv
// Bench for kf_regbank: instance 0 is DEPTH=8 combinational read, instance 1 is DEPTH=6
// registered read; read results go through a due-cycle scoreboard fed by a reference model.
module tb_kf_regbank;

    localparam int W   = 24;
    localparam int AW  = 3;
    localparam int NRD = 2;
    localparam int NSC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_i      [2];
    logic               wr_en_i    [2];
    logic [AW-1:0]      wr_addr_i  [2];
    logic [W-1:0]       wr_data_i  [2];
    logic               wr_ready_o [2];
    logic [NRD*AW-1:0]  rd_addr_i  [2];
    logic [NRD*W-1:0]   rd_data_o  [2];
    logic               clr_req_i  [2];
    logic               busy_o     [2];
    logic               clr_done_o [2];
    logic               addr_err_o [2];
    logic [NSC-1:0]     sc_we_i    [2];
    logic [NSC*W-1:0]   sc_d_i     [2];
    logic [NSC*W-1:0]   sc_q_o     [2];

    kf_regbank #(.W(W), .DEPTH(8), .ADDRW(AW), .NRD(NRD), .NSC(NSC), .RD_LAT(0)) u0 (
        .clk(clk), .rst(rst_i[0]), .wr_en(wr_en_i[0]), .wr_addr(wr_addr_i[0]),
        .wr_data(wr_data_i[0]), .wr_ready(wr_ready_o[0]), .rd_addr(rd_addr_i[0]),
        .rd_data(rd_data_o[0]), .clr_req(clr_req_i[0]), .busy(busy_o[0]),
        .clr_done(clr_done_o[0]), .addr_err(addr_err_o[0]), .sc_we(sc_we_i[0]),
        .sc_d(sc_d_i[0]), .sc_q(sc_q_o[0])
    );

    kf_regbank #(.W(W), .DEPTH(6), .ADDRW(AW), .NRD(NRD), .NSC(NSC), .RD_LAT(1)) u1 (
        .clk(clk), .rst(rst_i[1]), .wr_en(wr_en_i[1]), .wr_addr(wr_addr_i[1]),
        .wr_data(wr_data_i[1]), .wr_ready(wr_ready_o[1]), .rd_addr(rd_addr_i[1]),
        .rd_data(rd_data_o[1]), .clr_req(clr_req_i[1]), .busy(busy_o[1]),
        .clr_done(clr_done_o[1]), .addr_err(addr_err_o[1]), .sc_we(sc_we_i[1]),
        .sc_d(sc_d_i[1]), .sc_q(sc_q_o[1])
    );

    typedef struct {
        string        tag;
        int           inst;
        int           port;
        logic [W-1:0] exp;
        int           due;
    } sb_t;

    sb_t  sbq [$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   run = 1'b0;

    int           walk [2];
    logic         err  [2];
    logic [W-1:0] mem  [2][8];
    logic [W-1:0] scm  [2][2];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int dep(input int i);
        return (i == 0) ? 8 : 6;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            sb_t e;
            e = sbq.pop_front();
            if (e.due < cyc)
                check_val({e.tag, ".due"}, 64'(cyc), 64'(e.due));
            else
                check_val(e.tag, 64'(rd_data_o[e.inst][e.port*W +: W]), 64'(e.exp));
        end
    end

    task automatic model_edge(input int i);
        int pre;
        pre = walk[i];
        if (rst_i[i]) begin
            walk[i]   = dep(i);
            err[i]    = 1'b0;
            scm[i][0] = '0;
            scm[i][1] = '0;
        end else begin
            if (pre > 0) begin
                mem[i][dep(i) - pre] = '0;
                walk[i] = pre - 1;
            end else if (wr_en_i[i]) begin
                if (int'(wr_addr_i[i]) < dep(i))
                    mem[i][wr_addr_i[i]] = wr_data_i[i];
                else
                    err[i] = 1'b1;
            end
            for (int k = 0; k < NRD; k++)
                if (int'(rd_addr_i[i][k*AW +: AW]) >= dep(i))
                    err[i] = 1'b1;
            if (pre == 0 && clr_req_i[i]) begin
                walk[i] = dep(i);
                err[i]  = 1'b0;
            end
            for (int j = 0; j < NSC; j++)
                if (sc_we_i[i][j])
                    scm[i][j] = sc_d_i[i][j*W +: W];
        end
    endtask

    // One clock: queue expected reads, advance the model, then check registered status.
    task automatic tick();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < NRD; k++) begin
                logic [AW-1:0] ra;
                logic [W-1:0]  x;
                sb_t           e;
                ra = rd_addr_i[i][k*AW +: AW];
                if (walk[i] > 0 || int'(ra) >= dep(i))
                    x = '0;
                else if (wr_en_i[i] && !rst_i[i] && ra == wr_addr_i[i])
                    x = wr_data_i[i];
                else
                    x = mem[i][ra];
                if (i == 1 && rst_i[i])
                    x = '0;
                if (run) begin
                    e.tag  = $sformatf("u%0d.rd%0d.a%0d.c%0d", i, k, ra, cyc);
                    e.inst = i;
                    e.port = k;
                    e.exp  = x;
                    e.due  = cyc + i;
                    sbq.push_back(e);
                end
            end
        end
        for (int i = 0; i < 2; i++)
            model_edge(i);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("u%0d.busy", i),     64'(busy_o[i]),     64'(walk[i] > 0));
            check_val($sformatf("u%0d.clr_done", i), 64'(clr_done_o[i]), 64'(walk[i] == 1));
            check_val($sformatf("u%0d.wr_ready", i), 64'(wr_ready_o[i]), 64'(walk[i] == 0));
            check_val($sformatf("u%0d.addr_err", i), 64'(addr_err_o[i]), 64'(err[i]));
            check_val($sformatf("u%0d.sc_q", i),     64'(sc_q_o[i]),     64'({scm[i][1], scm[i][0]}));
            rst_i[i]     = 1'b0;
            wr_en_i[i]   = 1'b0;
            clr_req_i[i] = 1'b0;
            sc_we_i[i]   = '0;
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input int i, input int a, input logic [W-1:0] d);
        wr_en_i[i]   = 1'b1;
        wr_addr_i[i] = AW'(a);
        wr_data_i[i] = d;
    endtask

    task automatic rd(input int i, input int a0, input int a1);
        rd_addr_i[i] = {AW'(a1), AW'(a0)};
    endtask

    task automatic readback_all();
        for (int a = 0; a < 8; a++) begin
            rd(0, a, 7 - a);
            rd(1, a % 6, 5 - (a % 6));
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_i[i] = 1'b1; wr_en_i[i] = 1'b0; clr_req_i[i] = 1'b0; sc_we_i[i] = '0;
            wr_addr_i[i] = '0; wr_data_i[i] = '0; rd_addr_i[i] = '0; sc_d_i[i] = '0;
            walk[i] = 0; err[i] = 1'b0;
        end
        tick();
        run = 1'b1;

        // Post-reset walk, then every entry reads zero.
        ticks(8);
        readback_all();

        // Fill with the A5/index/5A pattern while reading the address being written.
        for (int a = 0; a < 8; a++) begin
            wr(0, a, {8'hA5, 8'(a), 8'h5A});
            rd(0, a, 7 - a);
            if (a < 6) begin
                wr(1, a, {8'hA5, 8'(a), 8'h5A});
                rd(1, a, 5 - a);
            end
            tick();
        end
        readback_all();

        // Same-cycle write-through / same-edge forwarding.
        wr(0, 3, 24'hDEADBE); rd(0, 3, 0);
        wr(1, 3, 24'hDEADBE); rd(1, 3, 0);
        ticks(2);
        wr(1, 5, 24'h123456); rd(1, 0, 5);
        ticks(2);

        // Reset on the registered-read instance zeroes rd_data next cycle.
        rst_i[1] = 1'b1;
        tick();
        ticks(6);
        rd(1, 5, 3);
        tick();

        // Clear with a simultaneous write, a repeated clr_req and a dropped write mid-walk.
        rd(1, 0, 1);
        clr_req_i[0] = 1'b1; wr(0, 2, 24'h777777); rd(0, 2, 2);
        tick();
        ticks(3);
        clr_req_i[0] = 1'b1; wr(0, 4, 24'h444444);
        tick();
        ticks(3);
        readback_all();

        // Reset in the middle of a clear restarts the walk.
        wr(0, 6, 24'h0F0F0F); rd(0, 6, 0);
        tick();
        clr_req_i[0] = 1'b1;
        ticks(3);
        rst_i[0] = 1'b1;
        tick();
        ticks(8);
        readback_all();

        // Out-of-range accesses on the DEPTH=6 instance.
        wr(1, 1, 24'h111111); rd(1, 1, 0);
        tick();
        wr(1, 7, 24'hBADBAD);
        tick();
        wr(1, 6, 24'hBADBAD);
        tick();
        rd(1, 6, 1);
        tick();
        rd(1, 1, 2);
        ticks(3);
        clr_req_i[1] = 1'b1;
        tick();
        ticks(5);
        readback_all();

        // Scalars: load, hold, survive a clear, zeroed by reset.
        for (int i = 0; i < 2; i++) begin
            sc_we_i[i] = 2'b11;
            sc_d_i[i]  = {24'h223333, 24'h001111};
        end
        tick();
        for (int i = 0; i < 2; i++)
            sc_d_i[i] = {24'hCCDDEE, 24'hAABBCC};
        ticks(3);
        clr_req_i[0] = 1'b1; clr_req_i[1] = 1'b1;
        tick();
        ticks(8);
        rst_i[0] = 1'b1; rst_i[1] = 1'b1;
        tick();
        ticks(8);

        run = 1'b0;
        ticks(2);
        check_val("sb.empty", 64'(sbq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kf_regbank.md
Name: kf_regbank

Overview:
- Parametrised successor to the Kalman-filter data-bank/scalar-register block.
- Holds one DEPTH×W register bank with one write port and NRD read ports, plus NSC independent scalar registers (the generalisation of the RQ/RD pair).
- Adds synchronous reset, a sequential bank-clear engine with busy/done handshake, out-of-range address detection and an optional registered read path.
- Sits between the KF datapath sequencer and the matrix/vector arithmetic units.

Parameters:
- W, 24, data width in bits.
- DEPTH, 40, number of bank entries (need not be a power of two).
- ADDRW, 6, address width; must satisfy 2^ADDRW >= DEPTH.
- NRD, 2, number of read ports (>=1).
- NSC, 2, number of scalar registers (>=1).
- RD_LAT, 0, read latency: 0 = combinational read, 1 = registered read.

Ports:
- clk  in  1  sole clock; everything updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- wr_addr  in  ADDRW  write address.
- wr_data  in  W  write data.
- wr_ready  out  1  high when a write is accepted (equals ~busy).
- rd_addr  in  NRD*ADDRW  packed read addresses; port k uses bits [k*ADDRW +: ADDRW].
- rd_data  out  NRD*W  packed read data; port k uses bits [k*W +: W].
- clr_req  in  1  single-cycle request to zero the whole bank.
- busy  out  1  clear engine active.
- clr_done  out  1  one-cycle pulse marking the final clear write.
- addr_err  out  1  sticky out-of-range flag.
- sc_we  in  NSC  per-scalar write enable.
- sc_d  in  NSC*W  packed scalar write data.
- sc_q  out  NSC*W  packed scalar outputs.

Behaviour:
- FSM states and transitions:
  - IDLE -> CLEAR when clr_req=1.
  - CLEAR -> IDLE after the entry at address DEPTH-1 is written.
  - Any state -> CLEAR on rst.
- Clear engine:
  - Pointer starts at 0. One entry is written with zero per cycle, pointer increments.
  - busy=1 for exactly DEPTH consecutive cycles.
  - clr_done=1 in the cycle the pointer equals DEPTH-1, while busy is still 1.
  - clr_req while busy is ignored and the walk does not restart.
- Reset (synchronous, also applies when asserted mid-clear):
  - In the cycle after rst is sampled: busy=1, pointer=0, sc_q=0, addr_err=0, clr_done=0, registered rd_data=0.
  - The bank is not flash-cleared; the automatic post-reset walk zeroes it over DEPTH cycles.
  - rst asserted mid-clear restarts the walk from 0.
- Write port:
  - The bank is written at the edge when wr_en & ~busy & (wr_addr < DEPTH).
  - wr_en while busy: write dropped silently, no error.
  - wr_en with wr_addr >= DEPTH (and not busy): write ignored, addr_err set.
- Read, RD_LAT=0:
  - rd_data[k] combinationally reflects bank[rd_addr[k]].
  - Write-through: if wr_en & ~busy & wr_addr==rd_addr[k] (in range), rd_data[k]=wr_data in the same cycle.
- Read, RD_LAT=1:
  - rd_data[k] is registered. The value seen after edge n is the bank contents including any write accepted at edge n (same-edge forwarding).
- Read forcing and errors (both latencies):
  - rd_data is forced to 0 while busy (for RD_LAT=1, forced to 0 when busy at the sampling edge).
  - An out-of-range rd_addr[k] (>= DEPTH) returns 0 and sets addr_err.
  - addr_err is cleared only by rst or an accepted clr_req.
- Scalars:
  - sc_q[j] loads sc_d[j] on the edge where sc_we[j]=1, otherwise holds.
  - Scalars are unaffected by clear and busy; only rst zeroes them.
- Simultaneous events:
  - rst has priority over clr_req, writes and scalar writes.
  - clr_req together with wr_en in IDLE: the write is accepted at that edge, then the clear begins and wipes it.
- Arithmetic:
  - Pointer width is ADDRW. Comparisons against DEPTH are unsigned; no wrap is ever reached because the walk terminates at DEPTH-1.

Test Plan:
- Reset walk (DEPTH=8, ADDRW=3): pulse rst for 1 cycle -> busy=1 for exactly 8 cycles, clr_done pulses on the 8th, wr_ready=0 throughout, rd_data=0; afterwards all 8 addresses read 000000.
- Fill/readback (RD_LAT=0, NRD=2): write {A5,i,5A} to i=0..7, read port0=i and port1=7-i -> both match the pattern; writing 0xDEADBE to address 3 while port0 reads 3 -> rd_data port0 = DEADBE in the same cycle.
- Registered read (RD_LAT=1):
  - Write 0x123456 to address 5 with port1 reading 5 at the same edge -> rd_data port1 = 123456 one cycle later.
  - Assert rst -> rd_data = 0 next cycle.
- Clear handshake: fill the bank, pulse clr_req -> busy for 8 cycles, second clr_req mid-walk ignored (walk still ends after 8), wr_en mid-walk dropped -> all entries 0 afterwards.
- Out of range (DEPTH=6, ADDRW=3): write address 7 -> no bank change, addr_err=1; read address 6 -> 0; addr_err stays 1 until clr_req, then reads 0.
- Scalars (NSC=2): write 001111 to scalar 0 and 223333 to scalar 1 -> held while sc_we=0 with sc_d changed to AABBCC/CCDDEE; clr_req leaves them intact; rst zeroes both.
